bayer_gray_binner: RTL and testbench

//  Upstream feeder for the grayscale image-processing stage. Consumes the raw 12-bit Bayer

---
 rtl/bayer_pkg.sv | 21 ++
 rtl/bin_line_buffer.sv | 36 +++
 rtl/bayer_gray_binner.sv | 138 +++++++++++++
 tb/tb_bayer_gray_binner.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/bayer_pkg.sv
// Shared types and defaults for the Bayer 2x2 grayscale binner.
//   BAYER_DATA_W : default raw/gray pixel width
//   bin_state_t  : frame walker states (IDLE, TOP, BOT)
//   pixel_t      : raw or binned pixel
//   pair_t       : sum of two horizontally adjacent pixels (line-buffer word)
//   sum_t        : full quad sum (R+G1+G2+B), never overflows
package bayer_pkg;

  localparam int BAYER_DATA_W = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TOP  = 2'd1,
    BOT  = 2'd2
  } bin_state_t;

  typedef logic [BAYER_DATA_W-1:0] pixel_t;
  typedef logic [BAYER_DATA_W:0]   pair_t;
  typedef logic [BAYER_DATA_W+1:0] sum_t;

endpackage

// File: rtl/bin_line_buffer.sv
// Simple dual-port RAM holding the top-row pair sums of each Bayer quad.
// Synchronous read with one clock of latency; the read register holds its
// value until the next read, so the consumer may use it after input gaps.
// No reset on the array or the read register; contents are don't-care.
//   clk       : clock
//   i_wr_en   : write strobe
//   i_wr_addr : write address
//   i_wr_data : write data
//   i_rd_en   : read strobe
//   i_rd_addr : read address
//   o_rd_data : read data, valid the clock after i_rd_en
module bin_line_buffer #(
  parameter int DEPTH = 320,
  parameter int WIDTH = 13,
  parameter int AW    = 9
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/bayer_gray_binner.sv
// 2x2 Bayer binner: sums each R/G1/G2/B quad and divides by four, producing
// one grayscale pixel per quad (IMG_W/2 x IMG_H/2 per frame).
// Top (even) rows store pair sums in a line buffer; bottom (odd) rows read
// them back and complete the quad.
// Build option: define GRAY_ROUND_EN for round-half-up, else truncation.
//   clk, rst   : clock, synchronous active-high reset
//   in_data    : raw Bayer pixel, qualified by in_valid
//   in_valid   : input pixel strobe (gaps allowed, no backpressure)
//   in_sof     : first pixel of a frame, qualified by in_valid
//   out_data   : binned pixel
//   out_valid  : one-cycle strobe per binned pixel
//   out_sof    : with out_valid on quad (0,0)
//   out_eof    : with out_valid on the last quad of the frame
//   frame_err  : one-cycle pulse when in_sof arrives mid-frame
module bayer_gray_binner
  import bayer_pkg::*;
#(
  parameter int DATA_W = BAYER_DATA_W,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_sof,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_sof,
  output logic              out_eof,
  output logic              frame_err
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int AW = CW - 1;
  localparam int BW = DATA_W + 1;
  localparam int SW = DATA_W + 2;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  bin_state_t        r_state, w_state_nxt;
  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic [DATA_W-1:0] r_pix_even;

  logic              w_restart, w_active, w_even, w_row_end, w_frame_end;
  logic              w_wr_en, w_rd_en, w_quad;
  logic [BW-1:0]     w_pair, w_rd_data;
  logic [SW-1:0]     w_sum, w_sum_adj;
  logic [DATA_W-1:0] w_gray;

  // Any qualified sof restarts the frame, whatever state we are in.
  assign w_restart   = in_valid & in_sof;
  assign w_active    = in_valid & ~in_sof & (r_state != IDLE);
  assign w_even      = ~r_col[0];
  assign w_row_end   = (r_col == COL_LAST);
  assign w_frame_end = w_row_end & (r_row == ROW_LAST);

  // Horizontal pair sum, shared by the buffer write (top) and quad sum (bottom).
  assign w_pair  = BW'(r_pix_even) + BW'(in_data);
  assign w_wr_en = w_active & (r_state == TOP) & ~w_even;
  assign w_rd_en = w_active & (r_state == BOT) &  w_even;
  assign w_quad  = w_active & (r_state == BOT) & ~w_even;
  assign w_sum   = SW'(w_rd_data) + SW'(w_pair);

`ifdef GRAY_ROUND_EN
  assign w_sum_adj = w_sum + SW'(2);
`else
  assign w_sum_adj = w_sum;
`endif
  assign w_gray = DATA_W'(w_sum_adj >> 2);

  bin_line_buffer #(
    .DEPTH (IMG_W / 2),
    .WIDTH (BW),
    .AW    (AW)
  ) u_lbuf (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_col[CW-1:1]),
    .i_wr_data (w_pair),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_col[CW-1:1]),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_restart) begin
      w_state_nxt = TOP;
    end else if (w_active && w_row_end) begin
      if (r_state == TOP)        w_state_nxt = BOT;
      else if (r_row == ROW_LAST) w_state_nxt = IDLE;
      else                       w_state_nxt = TOP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col      <= '0;
      r_row      <= '0;
      r_pix_even <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      out_eof    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      out_valid <= w_quad;
      out_sof   <= w_quad & (r_row == RW'(1)) & (r_col == CW'(1));
      out_eof   <= w_quad & w_frame_end;
      frame_err <= w_restart & (r_state != IDLE);
      if (w_quad) out_data <= w_gray;

      // The sof pixel itself is (0,0), so the next one lands on column 1.
      if (w_restart) begin
        r_col      <= CW'(1);
        r_row      <= '0;
        r_pix_even <= in_data;
      end else if (w_active) begin
        if (w_even) r_pix_even <= in_data;
        if (w_row_end) begin
          r_col <= '0;
          r_row <= w_frame_end ? '0 : r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bayer_gray_binner.sv
module tb_bayer_gray_binner;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] in_data;
  logic        in_valid;
  logic        in_sof;
  logic [11:0] out_data;
  logic        out_valid;
  logic        out_sof;
  logic        out_eof;
  logic        frame_err;

  bayer_gray_binner #(.DATA_W(12), .IMG_W(4), .IMG_H(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_sof   (out_sof),
    .out_eof   (out_eof),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] d;
    logic        sof;
    logic        eof;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          err_q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [11:0] frame_px[16];
  logic [11:0] frame_ex[4];
  exp_t        e;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard whenever the DUT presents a result.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: data=%0d sof=%0b eof=%0b cyc=%0d, required no output",
                   out_data, out_sof, out_eof, cyc);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.d || out_sof !== e.sof || out_eof !== e.eof || cyc != e.cyc) begin
            errors++;
            $display("FAIL out_pixel: got data=%0d sof=%0b eof=%0b cyc=%0d, required data=%0d sof=%0b eof=%0b cyc=%0d",
                     out_data, out_sof, out_eof, cyc, e.d, e.sof, e.eof, e.cyc);
          end
        end
      end else if (out_sof || out_eof) begin
        checks++;
        errors++;
        $display("FAIL stray_flag: sof=%0b eof=%0b without out_valid, required 0 0", out_sof, out_eof);
      end
      if (frame_err) begin
        checks++;
        if (err_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_frame_err: cyc=%0d, required no pulse", cyc);
        end else begin
          int c;
          c = err_q.pop_front();
          if (c != cyc) begin
            errors++;
            $display("FAIL frame_err_cycle: got cyc=%0d, required cyc=%0d", cyc, c);
          end
        end
      end
    end
  end

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  // Drives frame_px[first..last]; on bottom-row odd columns of a live frame
  // the hand-computed quad result is pushed with its expected arrival cycle.
  task automatic send_pixels(input int first, input int last, input bit gaps,
                             input bit live, input bit sof_first, input bit exp_err);
    for (int i = first; i <= last; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) idle();
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = frame_px[i];
      in_sof   = sof_first && (i == first);
      if (sof_first && i == first && exp_err) err_q.push_back(cyc + 1);
      if (live && ((i / 4) % 2 == 1) && (i % 2 == 1)) begin
        int q;
        q = (i / 8) * 2 + (i % 4) / 2;
        exp_q.push_back('{frame_ex[q], q == 0, q == 3, cyc + 1});
      end
    end
    idle();
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (out_data !== 12'd0 || out_valid !== 1'b0 || out_sof !== 1'b0 ||
        out_eof !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL %s: data=%0d valid=%0b sof=%0b eof=%0b err=%0b, required all 0",
               name, out_data, out_valid, out_sof, out_eof, frame_err);
    end
  endtask

  task automatic load_const(input logic [11:0] v);
    for (int i = 0; i < 16; i++) frame_px[i] = v;
    for (int q = 0; q < 4; q++) frame_ex[q] = v;
  endtask

  task automatic load_ramp();
    frame_px = '{12'd10,  12'd20,  12'd30,  12'd40,
                 12'd50,  12'd60,  12'd70,  12'd80,
                 12'd100, 12'd200, 12'd300, 12'd400,
                 12'd500, 12'd600, 12'd700, 12'd800};
    frame_ex = '{12'd35, 12'd55, 12'd350, 12'd550};
  endtask

  initial begin
    rst      = 1'b1;
    in_data  = '0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_zero("reset_state");

    // Constant frame, back to back.
    load_const(12'd100);
    send_pixels(0, 15, 0, 1, 1, 0);

    // Rounding-sensitive quads plus saturation at full scale.
    frame_px = '{12'd1, 12'd2, 12'd4095, 12'd4095,
                 12'd3, 12'd4, 12'd4095, 12'd4095,
                 12'd1, 12'd1, 12'd4095, 12'd4095,
                 12'd2, 12'd2, 12'd4095, 12'd4095};
`ifdef GRAY_ROUND_EN
    frame_ex = '{12'd3, 12'd4095, 12'd2, 12'd4095};
`else
    frame_ex = '{12'd2, 12'd4095, 12'd1, 12'd4095};
`endif
    send_pixels(0, 15, 0, 1, 1, 0);

    // Random gaps on the constant frame and on a distinct-value frame.
    load_const(12'd100);
    send_pixels(0, 15, 1, 1, 1, 0);
    load_ramp();
    send_pixels(0, 15, 1, 1, 1, 0);

    // sof on the 6th pixel: partial frame dropped, new frame restarts there.
    load_ramp();
    send_pixels(0, 4, 0, 0, 1, 0);
    send_pixels(0, 15, 0, 1, 1, 1);

    // sof on the last pixel position: no eof for the truncated frame.
    load_ramp();
    send_pixels(0, 14, 0, 1, 1, 0);
    load_const(12'd100);
    send_pixels(0, 15, 0, 1, 1, 1);

    // Reset on the 9th pixel, trailing pixels ignored, then a clean frame.
    load_ramp();
    send_pixels(0, 7, 0, 1, 1, 0);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = frame_px[8];
    in_sof   = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    check_zero("mid_frame_reset");
    rst = 1'b0;
    in_valid = 1'b0;
    send_pixels(9, 15, 0, 0, 0, 0);
    send_pixels(0, 15, 1, 1, 1, 0);

    repeat (6) idle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_outputs: %0d outstanding, required 0", exp_q.size());
    end
    checks++;
    if (err_q.size() != 0) begin
      errors++;
      $display("FAIL missing_frame_err: %0d outstanding, required 0", err_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
